// File: rtl/tlp_rx_snoop_capture.sv
// Passive snoop of the 64-bit PCIe RX stream into the encapsulation FIFO, whole TLPs only.
// Optional type filter (mem rd/wr and completions only) when NETTLP_SNOOP_FILTER_EN is defined.
module tlp_rx_snoop_capture #(
   parameter int FIFO_HEADROOM = 4,
   parameter int DROP_CNT_W    = 32,
   localparam int DIN_W        = 96
) (
   input  logic                  pcie_clk,
   input  logic                  pcie_rst,
   input  logic                  rx_tvalid,
   input  logic                  rx_tready,
   input  logic                  rx_tlast,
   input  logic [7:0]            rx_tkeep,
   input  logic [63:0]           rx_tdata,
   input  logic                  rx_err_fwd,
   input  logic                  snoop_en,
   input  logic                  prog_full,
   output logic                  wr_en,
   output logic [DIN_W-1:0]      din,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   typedef enum logic [2:0] {SYNC, IDLE, HDR, BODY, DROP} state_t;

   state_t                state_q, state_d;
   logic                  stg_vld_q, stg_vld_d;
   logic                  stg_last_q, stg_last_d;
   logic [7:0]            stg_keep_q, stg_keep_d;
   logic [63:0]           stg_data_q, stg_data_d;
   logic                  err_acc_q, err_acc_d;
   logic [12:0]           len_q, len_d;
   logic [7:0]            tag_q, tag_d;
   logic                  is_cpl_q, is_cpl_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic        beat;
   logic        wr_c;
   logic [2:0]  fmt;
   logic [3:0]  ty;
   logic [9:0]  len10;
   logic [12:0] sop_len;
   logic        is_cpl_in;
   logic        type_ok;
   logic [7:0]  out_tag;

   always_comb begin
      beat      = rx_tvalid & rx_tready;
      fmt       = rx_tdata[31:29];
      ty        = rx_tdata[28:25];
      len10     = rx_tdata[9:0];
      is_cpl_in = (ty == 4'b0101);
`ifdef NETTLP_SNOOP_FILTER_EN
      type_ok   = (ty == 4'b0000) || is_cpl_in;
`else
      type_ok   = 1'b1;
`endif
      sop_len   = (fmt[0] ? 13'd16 : 13'd12) +
                  (fmt[1] ? ((len10 == 10'd0) ? 13'd4096 : {1'b0, len10, 2'b00}) : 13'd0);
      // A tlast beat always leaves the stage on the next cycle; others wait for a successor.
      wr_c      = stg_vld_q & (stg_last_q | beat);

      state_d    = state_q;
      stg_vld_d  = stg_vld_q & ~wr_c;
      stg_last_d = stg_last_q;
      stg_keep_d = stg_keep_q;
      stg_data_d = stg_data_q;
      err_acc_d  = err_acc_q;
      len_d      = len_q;
      tag_d      = tag_q;
      is_cpl_d   = is_cpl_q;
      drop_cnt_d = drop_cnt_q;

      case (state_q)
         SYNC: if (beat && rx_tlast) state_d = IDLE;
         IDLE: begin
            if (beat && !rx_tlast) begin
               if (!snoop_en || prog_full || !type_ok) begin
                  state_d = DROP;
                  if (prog_full && (drop_cnt_q != {DROP_CNT_W{1'b1}}))
                     drop_cnt_d = drop_cnt_q + 1'b1;
               end else begin
                  state_d    = HDR;
                  stg_vld_d  = 1'b1;
                  stg_last_d = 1'b0;
                  stg_keep_d = rx_tkeep;
                  stg_data_d = rx_tdata;
                  err_acc_d  = rx_err_fwd;
                  len_d      = sop_len;
                  tag_d      = rx_tdata[47:40];
                  is_cpl_d   = is_cpl_in;
               end
            end
         end
         HDR, BODY: begin
            if (beat) begin
               state_d    = rx_tlast ? IDLE : BODY;
               stg_vld_d  = 1'b1;
               stg_last_d = rx_tlast;
               stg_keep_d = rx_tkeep;
               stg_data_d = rx_tdata;
               err_acc_d  = err_acc_q | rx_err_fwd;
               if ((state_q == HDR) && is_cpl_q) tag_d = rx_tdata[15:8];
            end
         end
         DROP: if (beat && rx_tlast) state_d = IDLE;
         default: state_d = SYNC;
      endcase

      // Completion tag lives in DW2, which is only visible as beat 0 leaves the stage.
      out_tag = ((state_q == HDR) && is_cpl_q) ? rx_tdata[15:8] : tag_q;
      wr_en   = wr_c & ~pcie_rst;
      din     = wr_en ? {1'b1, stg_last_q, stg_keep_q, stg_data_q, stg_last_q & err_acc_q,
                         len_q, out_tag} : '0;
      drop_cnt = drop_cnt_q;
   end

   always_ff @(posedge pcie_clk) begin
      if (pcie_rst) begin
         state_q    <= SYNC;
         stg_vld_q  <= 1'b0;
         stg_last_q <= 1'b0;
         stg_keep_q <= '0;
         stg_data_q <= '0;
         err_acc_q  <= 1'b0;
         len_q      <= '0;
         tag_q      <= '0;
         is_cpl_q   <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         stg_vld_q  <= stg_vld_d;
         stg_last_q <= stg_last_d;
         stg_keep_q <= stg_keep_d;
         stg_data_q <= stg_data_d;
         err_acc_q  <= err_acc_d;
         len_q      <= len_d;
         tag_q      <= tag_d;
         is_cpl_q   <= is_cpl_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

endmodule

// File: tb/tb_tlp_rx_snoop_capture.sv
// Scoreboard bench for tlp_rx_snoop_capture: directed TLPs, expected FIFO words queued at issue.
module tb_tlp_rx_snoop_capture;

   logic        pcie_clk = 1'b0;
   logic        pcie_rst = 1'b1;
   logic        rx_tvalid = 1'b0, rx_tready = 1'b0, rx_tlast = 1'b0, rx_err_fwd = 1'b0;
   logic [7:0]  rx_tkeep = '0;
   logic [63:0] rx_tdata = '0;
   logic        snoop_en = 1'b1, prog_full = 1'b0;
   logic        wr_en;
   logic [95:0] din;
   logic [31:0] drop_cnt;

   int n_cmp = 0;
   int n_err = 0;
   logic [95:0] sb[$];

   tlp_rx_snoop_capture #(.FIFO_HEADROOM(4), .DROP_CNT_W(32)) dut (
      .pcie_clk(pcie_clk), .pcie_rst(pcie_rst),
      .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tlast(rx_tlast),
      .rx_tkeep(rx_tkeep), .rx_tdata(rx_tdata), .rx_err_fwd(rx_err_fwd),
      .snoop_en(snoop_en), .prog_full(prog_full),
      .wr_en(wr_en), .din(din), .drop_cnt(drop_cnt)
   );

   always #5 pcie_clk = ~pcie_clk;

   function automatic logic [95:0] mkword(input logic last, input logic [7:0] keep,
                                          input logic [63:0] data, input logic tu,
                                          input logic [12:0] len, input logic [7:0] tag);
      return {1'b1, last, keep, data, tu, len, tag};
   endfunction

   task automatic chk(input string name, input logic [95:0] got, input logic [95:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%0h required=%0h", name, got, want);
      end
   endtask

   // One accepted beat; when cap is set the word the FIFO must eventually see is queued.
   task automatic beat(input logic last, input logic [7:0] keep, input logic [63:0] data,
                       input logic err, input logic cap, input logic tu,
                       input logic [12:0] len, input logic [7:0] tag);
      rx_tvalid = 1'b1; rx_tready = 1'b1; rx_tlast = last;
      rx_tkeep = keep; rx_tdata = data; rx_err_fwd = err;
      if (cap) sb.push_back(mkword(last, keep, data, tu, len, tag));
      @(posedge pcie_clk); #1;
   endtask

   task automatic idle(input int n);
      rx_tvalid = 1'b0; rx_tready = 1'b1; rx_tlast = 1'b0; rx_err_fwd = 1'b0;
      repeat (n) begin @(posedge pcie_clk); #1; end
   endtask

   always @(negedge pcie_clk) begin
      if (wr_en === 1'b1) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write got=%0h required=no write", din);
         end else begin
            logic [95:0] w;
            w = sb.pop_front();
            if (din !== w) begin
               n_err++;
               $display("FAIL din_word got=%0h required=%0h", din, w);
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge pcie_clk);
      @(negedge pcie_clk);
      chk("rst_wr_en", {95'd0, wr_en}, 96'd0);
      chk("rst_din", din, 96'd0);
      chk("rst_drop_cnt", {64'd0, drop_cnt}, 96'd0);
      @(posedge pcie_clk); #1;
      pcie_rst = 1'b0;
      idle(2);

      // tail of a packet in flight at reset: resynchronise only
      beat(1, 8'hFF, 64'h1111_2222_3333_4444, 0, 0, 0, 0, 0);
      idle(2);

      // MWr 3DW len=2, tag 0x1A, with a stall after beat 0
      beat(0, 8'hFF, 64'h00001A0F_40000002, 0, 1, 0, 13'd20, 8'h1A);
      rx_tvalid = 1'b1; rx_tready = 1'b0; rx_tdata = 64'hBAD0BAD0_BAD0BAD0;
      @(negedge pcie_clk);
      chk("stall_no_write", {95'd0, wr_en}, 96'd0);
      @(posedge pcie_clk); #1;
      beat(0, 8'hFF, 64'hA0A0A0A0_10000000, 0, 1, 0, 13'd20, 8'h1A);
      beat(0, 8'hFF, 64'hC0C0C0C0_B0B0B0B0, 0, 1, 0, 13'd20, 8'h1A);
      beat(1, 8'hFF, 64'hE0E0E0E0_D0D0D0D0, 0, 1, 0, 13'd20, 8'h1A);
      idle(2);

      // CplD 3DW len=1, DW2[15:8]=0x07 while DW1[15:8]=0x00
      beat(0, 8'hFF, 64'h01000004_4A000001, 0, 1, 0, 13'd16, 8'h07);
      beat(1, 8'hFF, 64'hDEADBEEF_00000700, 0, 1, 0, 13'd16, 8'h07);
      idle(2);

      // MRd 4DW len=0 -> 16 bytes
      beat(0, 8'hFF, 64'h0000330F_20000000, 0, 1, 0, 13'd16, 8'h33);
      beat(1, 8'hFF, 64'h00000000_00001000, 0, 1, 0, 13'd16, 8'h33);
      idle(2);

      // MWr 3DW len=0 -> 12 + 4096
      beat(0, 8'hFF, 64'h0000440F_40000000, 0, 1, 0, 13'd4108, 8'h44);
      beat(1, 8'h0F, 64'h00000000_00002000, 0, 1, 0, 13'd4108, 8'h44);
      idle(2);

      // capture disabled: dropped silently
      snoop_en = 1'b0;
      beat(0, 8'hFF, 64'h0000550F_40000001, 0, 0, 0, 0, 0);
      snoop_en = 1'b1;
      beat(1, 8'hFF, 64'h12345678_00003000, 0, 0, 0, 0, 0);
      idle(1);
      chk("snoop_off_no_count", {64'd0, drop_cnt}, 96'd0);

      // malformed single-beat TLP discarded
      beat(1, 8'hFF, 64'h0000660F_40000001, 0, 0, 0, 0, 0);
      idle(2);

      // prog_full at SOP only
      prog_full = 1'b1;
      beat(0, 8'hFF, 64'h0000770F_40000002, 0, 0, 0, 0, 0);
      prog_full = 1'b0;
      beat(0, 8'hFF, 64'h11111111_00004000, 0, 0, 0, 0, 0);
      beat(1, 8'hFF, 64'h33333333_22222222, 0, 0, 0, 0, 0);
      idle(1);
      chk("drop_cnt_one", {64'd0, drop_cnt}, 96'd1);
      beat(0, 8'hFF, 64'h0000880F_20000000, 0, 1, 0, 13'd16, 8'h88);
      beat(1, 8'hFF, 64'h00000000_00005000, 0, 1, 0, 13'd16, 8'h88);
      idle(2);

      // reset lands on beat 2 of a 5-beat TLP
      beat(0, 8'hFF, 64'h0000990F_40000006, 0, 0, 0, 0, 0);
      pcie_rst = 1'b1;
      beat(0, 8'hFF, 64'hAAAAAAAA_00006000, 0, 0, 0, 0, 0);
      pcie_rst = 1'b0;
      beat(0, 8'hFF, 64'hBBBBBBBB_BBBBBBBB, 0, 0, 0, 0, 0);
      beat(0, 8'hFF, 64'hCCCCCCCC_CCCCCCCC, 0, 0, 0, 0, 0);
      beat(1, 8'hFF, 64'hDDDDDDDD_DDDDDDDD, 0, 0, 0, 0, 0);
      idle(1);
      chk("drop_cnt_after_rst", {64'd0, drop_cnt}, 96'd0);
      beat(0, 8'hFF, 64'h0000AB0F_40000001, 0, 1, 0, 13'd16, 8'hAB);
      beat(1, 8'hFF, 64'h55555555_00007000, 0, 1, 0, 13'd16, 8'hAB);
      idle(2);

      // back-to-back: SOP right after tlast, poison on beat 2 of the first TLP
      beat(0, 8'hFF, 64'h00005C0F_40000001, 0, 1, 0, 13'd16, 8'h5C);
      beat(0, 8'hFF, 64'h66666666_00008000, 1, 1, 0, 13'd16, 8'h5C);
      beat(1, 8'hFF, 64'h77777777_77777777, 0, 1, 1, 13'd16, 8'h5C);
      beat(0, 8'hFF, 64'h00006D0F_00000001, 0, 1, 0, 13'd12, 8'h6D);
      beat(1, 8'h0F, 64'h00000000_00009000, 0, 1, 0, 13'd12, 8'h6D);
      idle(4);

      chk("scoreboard_drained", 96'(sb.size()), 96'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
